// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : seq_pkg
//  Description : Shared definitions for the "1011" detector and its serializer
//                front end: the ST_IDLE/ST_SHIFT state encoding and a helper
//                that sizes the serializer bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter width needed to index bits 0..w-1 (w >= 2, so never below 1).
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Parallel-to-serial front end for the "1011" detector. Accepts
//                WIDTH-bit words over valid/ready and shifts them out one bit
//                per clock on x. A one-word holding register lets consecutive
//                words stream without an idle bit between them.
//  Ports       : clk        rising-edge clock
//                reset      synchronous active-high reset
//                din        parallel input word
//                din_valid  din carries a word
//                din_ready  block can take a word this edge
//                x          serial output bit (IDLE_BIT when not shifting)
//                x_valid    x carries a data bit
//                word_done  last bit of a word is on x
//                busy       a word is shifting or waiting in hold
//  Revision    : 1.0  initial release
// ============================================================================
module bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic             hold_full_q, hold_full_d;

  logic [WIDTH-1:0] shifted;
  logic             cur_bit;
  logic             accept;

  // The output end of shreg depends on bit order; vacated positions take 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_bit = shreg_q[WIDTH-1];
      assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign cur_bit = shreg_q[0];
      assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  // Ready is gated by reset so a handshake in the reset cycle never counts.
  assign din_ready = !hold_full_q && !reset;
  assign accept    = din_valid && din_ready;

  assign x_valid   = (state_q == ST_SHIFT);
  assign x         = x_valid ? cur_bit : IDLE_BIT;
  assign word_done = x_valid && (cnt_q == LAST);
  assign busy      = x_valid || hold_full_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != LAST) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Drain hold; din_ready is low here so no accept can collide.
          shreg_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          // Word arriving on the last-bit edge goes straight to shreg.
          shreg_d = din;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule : bit_serializer
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Self-checking bench for bit_serializer. Two instances (MSB
//                first / idle 0 and LSB first / idle 1) share one stimulus
//                stream; each is compared every cycle against a word-level
//                model (current word + bits remaining + one held word).
//                Directed cases cover single words, bit order, back-to-back,
//                bypass, mid-word reset and detection of "1011" in the stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;

  logic [1:0] rdy, xo, xv, wd, bsy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy[0]), .x(xo[0]), .x_valid(xv[0]), .word_done(wd[0]), .busy(bsy[0])
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy[1]), .x(xo[1]), .x_valid(xv[1]), .word_done(wd[1]), .busy(bsy[1])
  );

  // Word-level model state per instance.
  logic [W-1:0] m_word [2];
  logic [W-1:0] m_hold [2];
  int           m_left [2];
  bit           m_hfull[2];

  // Observed-stream capture per instance.
  logic [15:0] cap    [2];
  int          run    [2];
  int          max_run[2];
  logic [3:0]  hist   [2];
  int          pos    [2];
  logic [7:0]  det    [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Emission index i of the word: MSB-first instance sends bit W-1-i.
  function automatic bit model_bit(input int k);
    int idx;
    idx = W - m_left[k];
    return (k == 0) ? m_word[k][W-1-idx] : m_word[k][idx];
  endfunction

  task automatic clear_caps();
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0; run[k] = 0; max_run[k] = 0;
      hist[k] = '0; pos[k] = 0; det[k] = '0;
    end
  endtask

  // One clock: apply inputs, check outputs against the model, advance model.
  task automatic step(input bit r, input bit v, input logic [W-1:0] d);
    @(negedge clk);
    reset = r; din_valid = v; din = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit ev, eb, er, acc;
      ev = (m_left[k] > 0);
      eb = ev ? model_bit(k) : (k == 1);
      er = !m_hfull[k] && !r;
      check_val($sformatf("x%0d", k),       32'(xo[k]),  32'(eb));
      check_val($sformatf("x_valid%0d", k), 32'(xv[k]),  32'(ev));
      check_val($sformatf("word_done%0d", k), 32'(wd[k]), 32'(m_left[k] == 1));
      check_val($sformatf("din_ready%0d", k), 32'(rdy[k]), 32'(er));
      check_val($sformatf("busy%0d", k),    32'(bsy[k]), 32'(ev || m_hfull[k]));

      if (xv[k]) begin
        cap[k] = {cap[k][14:0], xo[k]};
        run[k]++;
        if (run[k] > max_run[k]) max_run[k] = run[k];
        pos[k]++;
        hist[k] = {hist[k][2:0], xo[k]};
        if (hist[k] == 4'b1011 && pos[k] >= 1 && pos[k] <= 8) det[k][pos[k]-1] = 1'b1;
      end else begin
        run[k] = 0;
      end

      acc = v && er;
      if (r) begin
        m_left[k] = 0; m_hfull[k] = 1'b0;
      end else if (m_left[k] == 0) begin
        if (acc) begin m_word[k] = d; m_left[k] = W; end
      end else if (m_left[k] == 1) begin
        if (m_hfull[k]) begin
          m_word[k] = m_hold[k]; m_left[k] = W; m_hfull[k] = 1'b0;
        end else if (acc) begin
          m_word[k] = d; m_left[k] = W;
        end else begin
          m_left[k] = 0;
        end
      end else begin
        m_left[k]--;
        if (acc) begin m_hold[k] = d; m_hfull[k] = 1'b1; end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_word[k] = '0; m_hold[k] = '0; m_left[k] = 0; m_hfull[k] = 1'b0;
    end
    clear_caps();

    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'hEE);   // handshake during reset is ignored
    idle(2);

    // Single word, MSB first.
    clear_caps();
    step(1'b0, 1'b1, 8'hB0);
    idle(10);
    check_val("single_bits", 32'(cap[0][7:0]), 32'h0000_00B0);
    check_val("single_run",  32'(max_run[0]),  32'd8);

    // LSB first: 0x0D emits 1,0,1,1,0,0,0,0.
    clear_caps();
    step(1'b0, 1'b1, 8'h0D);
    idle(10);
    check_val("lsb_bits", 32'(cap[1][7:0]), 32'h0000_00B0);

    // Back-to-back through hold.
    clear_caps();
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'hC3);
    idle(18);
    check_val("b2b_bits", 32'(cap[0]),     32'h0000_5AC3);
    check_val("b2b_run",  32'(max_run[0]), 32'd16);

    // Bypass: next word presented exactly on the last-bit edge.
    clear_caps();
    step(1'b0, 1'b1, 8'h96);
    idle(7);
    step(1'b0, 1'b1, 8'hFF);
    idle(10);
    check_val("bypass_bits", 32'(cap[0]),     32'h0000_96FF);
    check_val("bypass_run",  32'(max_run[0]), 32'd16);

    // Reset after three bits of 0xA5 with 0x3C held.
    clear_caps();
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check_val("rst_busy",  32'(bsy[0]), 32'd0);
    check_val("rst_ready", 32'(rdy[0]), 32'd1);
    idle(12);
    check_val("rst_run",  32'(max_run[0]),   32'd3);
    check_val("rst_bits", 32'(cap[0][2:0]), 32'd5);

    // Overlapping detection of 1011 in 0xB6: hits on bits 4 and 7.
    clear_caps();
    step(1'b0, 1'b1, 8'hB6);
    idle(10);
    check_val("detect_mask", 32'(det[0]), 32'h0000_0048);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      bit r, v;
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 2) != 0);
      step(r, v, W'($urandom));
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bit_serializer
`default_nettype wire
